// File: rtl/ttt_token_processor_if.sv
// Bundled token/threshold inputs and event outputs of ttt_token_processor.
// The master side drives the stimulus and the slave side is the processor.
interface ttt_token_processor_if #(
  parameter int NEW_TOKENS_BITS = 4,
  parameter int TOKENS_BITS     = 8,
  parameter int DURATION_BITS   = 4
);
  logic                       ena;
  logic [NEW_TOKENS_BITS-1:0] new_good_tokens;
  logic [NEW_TOKENS_BITS-1:0] new_bad_tokens;
  logic [TOKENS_BITS-1:0]     good_tokens_threshold;
  logic [TOKENS_BITS-1:0]     bad_tokens_threshold;
  logic [DURATION_BITS-1:0]   duration;
  logic                       token_start;
  logic                       token_stop;
  logic                       active;
  logic [TOKENS_BITS-1:0]     good_count;

  modport master (
    output ena, new_good_tokens, new_bad_tokens,
           good_tokens_threshold, bad_tokens_threshold, duration,
    input  token_start, token_stop, active, good_count
  );

  modport slave (
    input  ena, new_good_tokens, new_bad_tokens,
           good_tokens_threshold, bad_tokens_threshold, duration,
    output token_start, token_stop, active, good_count
  );
endinterface

// File: rtl/ttt_token_processor.sv
// Tick-tock-tokens processor: saturating good/bad accumulators, veto/fire logic and a timed active window.
// Optional macro TTT_RETRIGGER_EN lets tokens keep accumulating and reload the timer while ACTIVE.
module ttt_token_processor #(
  parameter int NEW_TOKENS_BITS = 4,
  parameter int TOKENS_BITS     = 8,
  parameter int DURATION_BITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ttt_token_processor_if.slave  bus
);

  localparam int SUM_W = TOKENS_BITS + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                     state_q, state_d;
  logic [TOKENS_BITS-1:0]     good_q, good_d;
  logic [TOKENS_BITS-1:0]     bad_q, bad_d;
  logic [DURATION_BITS-1:0]   timer_q, timer_d;
  logic                       start_q, start_d;
  logic                       stop_q, stop_d;

  logic [NEW_TOKENS_BITS-1:0] new_good;
  logic [NEW_TOKENS_BITS-1:0] new_bad;
  logic [SUM_W-1:0]           g_sum;
  logic [SUM_W-1:0]           b_sum;
  logic [TOKENS_BITS-1:0]     g_next;
  logic [TOKENS_BITS-1:0]     b_next;
  logic                       veto;
  logic                       fire;

  assign new_good = bus.new_good_tokens;
  assign new_bad  = bus.new_bad_tokens;

  // One extra sum bit catches overflow so the accumulators clamp at all-ones.
  assign g_sum  = {1'b0, good_q} + SUM_W'(new_good);
  assign b_sum  = {1'b0, bad_q} + SUM_W'(new_bad);
  assign g_next = g_sum[TOKENS_BITS] ? {TOKENS_BITS{1'b1}} : g_sum[TOKENS_BITS-1:0];
  assign b_next = b_sum[TOKENS_BITS] ? {TOKENS_BITS{1'b1}} : b_sum[TOKENS_BITS-1:0];

  // A zero threshold disables its rule; veto is checked before fire wherever both apply.
  assign veto = (bus.bad_tokens_threshold != '0) && (b_next >= bus.bad_tokens_threshold);
  assign fire = (bus.good_tokens_threshold != '0) && (g_next >= bus.good_tokens_threshold);

`ifdef TTT_RETRIGGER_EN
  logic retrig;
`endif

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    timer_d = timer_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
`ifdef TTT_RETRIGGER_EN
    retrig  = 1'b0;
`endif
    if (bus.ena) begin
      case (state_q)
        IDLE: begin
          if (veto) begin
            good_d = '0;
            bad_d  = '0;
          end else if (fire) begin
            state_d = ACTIVE;
            timer_d = bus.duration;
            start_d = 1'b1;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            good_d = g_next;
            bad_d  = b_next;
          end
        end
        ACTIVE: begin
`ifdef TTT_RETRIGGER_EN
          if (veto) begin
            good_d = '0;
            bad_d  = '0;
          end else if (fire) begin
            retrig  = 1'b1;
            timer_d = bus.duration;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            good_d = g_next;
            bad_d  = b_next;
          end
          // A reload on the last window cycle suppresses the exit.
          if (!retrig) begin
            if (timer_q == '0) begin
              state_d = IDLE;
              stop_d  = 1'b1;
            end else begin
              timer_d = timer_q - 1'b1;
            end
          end
`else
          good_d = '0;
          bad_d  = '0;
          if (timer_q == '0) begin
            state_d = IDLE;
            stop_d  = 1'b1;
          end else begin
            timer_d = timer_q - 1'b1;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      good_q  <= '0;
      bad_q   <= '0;
      timer_q <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      timer_q <= timer_d;
      start_q <= start_d;
      stop_q  <= stop_d;
    end
  end

  assign bus.token_start = start_q;
  assign bus.token_stop  = stop_q;
  assign bus.active      = (state_q == ACTIVE);
  assign bus.good_count  = good_q;

endmodule

// File: doc/ttt_token_processor.md
Name: ttt_token_processor

Overview:
Tick-tock-tokens event processor that sits directly behind the TinyTapeout top-level pin wrapper. It integrates per-cycle "good" and "bad" token arrivals into two saturating counters. When good tokens reach their threshold without a bad-token veto, it emits a token_start pulse, holds an active window of programmable duration, then emits a token_stop pulse. The top wrapper drives its inputs from ui_in/uio_in and routes token_start/token_stop to uo_out[0]/uo_out[1].

Parameters:
NEW_TOKENS_BITS, 4, width of per-cycle token arrival inputs
TOKENS_BITS, 8, width of accumulators and thresholds (must be >= NEW_TOKENS_BITS)
DURATION_BITS, 4, width of active-window duration

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
ena  input  1  processing enable; low = hold all state
new_good_tokens  input  NEW_TOKENS_BITS  good tokens arriving this cycle
new_bad_tokens  input  NEW_TOKENS_BITS  bad tokens arriving this cycle
good_tokens_threshold  input  TOKENS_BITS  fire level; 0 = firing disabled
bad_tokens_threshold  input  TOKENS_BITS  veto level; 0 = veto disabled
duration  input  DURATION_BITS  active window length minus one, in cycles
token_start  output  1  one-cycle pulse, first cycle of the active window
token_stop  output  1  one-cycle pulse, first cycle after the active window
active  output  1  high for the whole active window
good_count  output  TOKENS_BITS  current good accumulator

Behaviour:
- One clock domain. Reset is synchronous and active-low: clk, rst_n.
- Reset values: state=IDLE, good_count=0, bad_count=0, timer=0, token_start=0, token_stop=0, active=0.
- All outputs are registered.
- Saturating accumulate:
  - g_next = min(good_count + new_good_tokens, 2^TOKENS_BITS-1)
  - b_next = same rule for bad tokens.
  - Inputs are zero-extended.
- ena=0: counters, state and timer hold. token_start and token_stop still clear to 0, so a pulse is never stretched.
- States: IDLE, ACTIVE. active = (state==ACTIVE).
- IDLE, ena=1, evaluated in priority order:
  1. Veto: bad_tokens_threshold!=0 and b_next >= bad_tokens_threshold. Clear both counters; stay IDLE; no pulse. Veto wins over a simultaneous fire.
  2. Fire: good_tokens_threshold!=0 and g_next >= good_tokens_threshold. Go to ACTIVE; timer<=duration; token_start<=1; clear both counters.
  3. Otherwise: good_count<=g_next, bad_count<=b_next.
- Latency: an input cycle that crosses the threshold produces token_start and active high on the next cycle.
- ACTIVE, ena=1:
  - timer==0: state<=IDLE, token_stop<=1.
  - else: timer<=timer-1.
  - The active window is exactly duration+1 enabled cycles. duration=0 gives a 1-cycle window.
  - token_stop is high in the first IDLE cycle; active is already 0 in that cycle.
- Without the optional feature, counters are held at 0 in ACTIVE and token inputs are ignored.
- IDLE after token_stop accumulates from 0 in the same cycle token_stop is high. Back-to-back windows are therefore possible: the earliest next token_start is 1 cycle after token_stop.
- Thresholds and duration are sampled only at the fire/reload moment. Changing them mid-window has no effect on the current timer.
- rst_n=0 mid-window: the next cycle is IDLE with no token_stop emitted.

Optional Feature:
TTT_RETRIGGER_EN:
- Defined:
  - In ACTIVE, counters accumulate and the veto rule applies, using the same priority as IDLE.
  - A fire condition in ACTIVE reloads timer<=duration and clears counters. No extra token_start is emitted.
  - A retrigger on the timer==0 cycle takes priority over exit, so no token_stop is emitted.
- Undefined: behaviour is as described in Behaviour above.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with inputs nonzero -> all outputs 0, good_count=0.
- Fire, basic window:
  - Stimulus: thr_good=8, thr_bad=0, duration=3, good=3 per cycle.
  - Cycles 1-2 -> good_count=3, then 6.
  - Cycle 3 -> token_start on the next cycle; active high for 4 cycles; token_stop on the following cycle; good_count=0 at token_start.
- Veto priority: thr_good=4, thr_bad=2, one cycle with good=5 and bad=2 -> no token_start, both counters 0.
- Saturation, TOKENS_BITS=8: thr_good=0, good=15 for 20 cycles -> good_count sticks at 255, never wraps; no firing.
- ena gating:
  - Mid-window, drop ena for 5 cycles -> active stays 1 and the timer freezes.
  - Total active cycles = duration+1+5.
  - ena low on the token_start cycle -> pulse width still 1.
- duration=0 plus TTT_RETRIGGER_EN:
  - Without the macro, a fire gives a 1-cycle active window and inputs during it are ignored.
  - With the macro, thr_good=2, duration=2, good=2 every cycle -> one token_start, active stays high, no token_stop until the input drops to 0.
